// File: rtl/class_argmax.sv
// Final classifier stage: adds a saturating bias to each class dot product and reports the arg-max.
// Optional macro RELU_EN clamps negative biased scores to zero before the compare.
module class_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int VALUE_SIZE  = 26,
    parameter int IDX_SIZE    = 4
) (
    input  logic                         clk,
    input  logic                         GlobalReset,
    input  logic                         start,
    input  logic                         dp_valid,
    output logic                         dp_ready,
    input  logic signed [VALUE_SIZE-1:0] dp_value,
    input  logic signed [VALUE_SIZE-1:0] dp_bias,
    output logic                         busy,
    output logic                         class_valid,
    output logic        [IDX_SIZE-1:0]   class_idx,
    output logic signed [VALUE_SIZE-1:0] class_score
);

    // state   | meaning
    // IDLE    | waiting for start; dot products ignored
    // COLLECT | accepting one dot product per class
    // DONE    | one-cycle result pulse, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    localparam logic signed [VALUE_SIZE-1:0] SCORE_MAX = {1'b0, {(VALUE_SIZE-1){1'b1}}};
    localparam logic signed [VALUE_SIZE-1:0] SCORE_MIN = {1'b1, {(VALUE_SIZE-1){1'b0}}};
    localparam logic [IDX_SIZE-1:0]          LAST_IDX  = IDX_SIZE'(NUM_CLASSES - 1);

    state_t                         state_q, state_d;
    logic        [IDX_SIZE-1:0]     count_q, count_d;
    logic        [IDX_SIZE-1:0]     best_idx_q, best_idx_d;
    logic signed [VALUE_SIZE-1:0]   best_score_q, best_score_d;
    logic        [IDX_SIZE-1:0]     class_idx_q, class_idx_d;
    logic signed [VALUE_SIZE-1:0]   class_score_q, class_score_d;

    logic signed [VALUE_SIZE:0]     sum_wide;
    logic signed [VALUE_SIZE-1:0]   score_sat;
    logic signed [VALUE_SIZE-1:0]   score;
    logic                           accept;
    logic                           take;

    // One extra bit of headroom; overflow shows up as the top two bits disagreeing.
    assign sum_wide = {dp_value[VALUE_SIZE-1], dp_value} + {dp_bias[VALUE_SIZE-1], dp_bias};

    always_comb begin
        score_sat = sum_wide[VALUE_SIZE-1:0];
        if (sum_wide[VALUE_SIZE] != sum_wide[VALUE_SIZE-1]) begin
            score_sat = sum_wide[VALUE_SIZE] ? SCORE_MIN : SCORE_MAX;
        end
    end

`ifdef RELU_EN
    assign score = score_sat[VALUE_SIZE-1] ? '0 : score_sat;
`else
    assign score = score_sat;
`endif

    assign accept = dp_valid && (state_q == S_COLLECT);
    // Strict compare keeps the lower index on ties.
    assign take   = (count_q == '0) || (score > best_score_q);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    count_d      = '0;
                    best_idx_d   = '0;
                    best_score_d = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (take) begin
                        best_idx_d   = count_q;
                        best_score_d = score;
                    end
                    // Result registers load with the final decision so they are valid during DONE.
                    if (count_q == LAST_IDX) begin
                        state_d       = S_DONE;
                        class_idx_d   = best_idx_d;
                        class_score_d = best_score_d;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            best_idx_q    <= '0;
            best_score_q  <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
        end
    end

    assign dp_ready    = (state_q == S_COLLECT);
    assign busy        = (state_q != S_IDLE);
    assign class_valid = (state_q == S_DONE);
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule

// File: tb/tb_class_argmax.sv
// Directed self-checking bench for class_argmax; expected results are hand-computed per scenario.
// Expectations for negative scores follow RELU_EN when the macro is defined.
module tb_class_argmax;

    logic               clk;
    logic               GlobalReset;
    logic               start;
    logic               dp_valid;
    logic               dp_ready;
    logic signed [25:0] dp_value;
    logic signed [25:0] dp_bias;
    logic               busy;
    logic               class_valid;
    logic        [3:0]  class_idx;
    logic signed [25:0] class_score;

    logic signed [25:0] vals   [10];
    logic signed [25:0] biases [10];

    int checks = 0;
    int errors = 0;

    class_argmax dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .start       (start),
        .dp_valid    (dp_valid),
        .dp_ready    (dp_ready),
        .dp_value    (dp_value),
        .dp_bias     (dp_bias),
        .busy        (busy),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic fill(input logic signed [25:0] v, input logic signed [25:0] b);
        for (int i = 0; i < 10; i++) begin
            vals[i]   = v;
            biases[i] = b;
        end
    endtask

    // Starts an image and feeds all ten classes; returns at the negedge of the DONE cycle.
    task automatic send_image(input bit gaps);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dp_valid = 1'b1;
            dp_value = vals[i];
            dp_bias  = biases[i];
            @(negedge clk);
            if (gaps && i < 9) begin
                dp_valid = 1'b0;
                dp_value = 26'sh1FFFFFF;
                dp_bias  = 26'sd0;
                @(negedge clk);
            end
        end
        dp_valid = 1'b0;
        dp_value = '0;
        dp_bias  = '0;
    endtask

    task automatic test_reset;
        GlobalReset = 1'b1;
        start = 1'b0; dp_valid = 1'b0; dp_value = '0; dp_bias = '0;
        #2;
        checks++; if (dp_ready !== 1'b0)    begin errors++; $display("FAIL reset_dp_ready got %0b exp 0", dp_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (class_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", class_valid); end
        checks++; if (class_idx !== 4'd0)   begin errors++; $display("FAIL reset_idx got %0d exp 0", class_idx); end
        checks++; if (class_score !== 26'sd0) begin errors++; $display("FAIL reset_score got %0d exp 0", class_score); end
        @(negedge clk) GlobalReset = 1'b0;
    endtask

    task automatic test_basic;
        fill(26'sd5, 26'sd0);
        vals[7] = 26'sd1000;
        send_image(1'b0);
        checks++; if (class_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", class_valid); end
        checks++; if (class_idx !== 4'd7)   begin errors++; $display("FAIL basic_idx got %0d exp 7", class_idx); end
        checks++; if (class_score !== 26'sd1000) begin errors++; $display("FAIL basic_score got %0d exp 1000", class_score); end
        checks++; if (busy !== 1'b1 || dp_ready !== 1'b0) begin errors++; $display("FAIL basic_done_flags got busy=%0b ready=%0b exp busy=1 ready=0", busy, dp_ready); end
        @(negedge clk);
        checks++; if (class_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse_end got valid=%0b busy=%0b exp 0 0", class_valid, busy); end
        @(negedge clk);
        checks++; if (class_idx !== 4'd7 || class_score !== 26'sd1000) begin errors++; $display("FAIL basic_hold got idx=%0d score=%0d exp 7 1000", class_idx, class_score); end
    endtask

    task automatic test_tie;
        fill(26'sd10, 26'sd0);
        vals[2] = 26'sd300;
        vals[5] = 26'sd300;
        send_image(1'b0);
        checks++; if (class_valid !== 1'b1 || class_idx !== 4'd2) begin errors++; $display("FAIL tie_idx got valid=%0b idx=%0d exp 1 2", class_valid, class_idx); end
        checks++; if (class_score !== 26'sd300) begin errors++; $display("FAIL tie_score got %0d exp 300", class_score); end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        fill(26'sd5, 26'sd0);
        vals[3]   = 26'sh1FFFFFF;
        biases[3] = 26'sd1;
        send_image(1'b0);
        checks++; if (class_idx !== 4'd3) begin errors++; $display("FAIL sat_pos_idx got %0d exp 3", class_idx); end
        checks++; if (class_score !== 26'sh1FFFFFF) begin errors++; $display("FAIL sat_pos_score got %0h exp 1ffffff", class_score); end
        @(negedge clk);
        // Most negative value plus -1 must clamp low, not wrap to the positive maximum.
        fill(-26'sd5, 26'sd0);
        vals[0]   = 26'sh2000000;
        biases[0] = -26'sd1;
        send_image(1'b0);
`ifdef RELU_EN
        checks++; if (class_idx !== 4'd0 || class_score !== 26'sd0) begin errors++; $display("FAIL sat_neg got idx=%0d score=%0d exp 0 0", class_idx, class_score); end
`else
        checks++; if (class_idx !== 4'd1 || class_score !== -26'sd5) begin errors++; $display("FAIL sat_neg got idx=%0d score=%0d exp 1 -5", class_idx, class_score); end
`endif
        @(negedge clk);
    endtask

    task automatic test_negative;
        for (int i = 0; i < 10; i++) begin
            vals[i]   = 26'(-10 * (i + 1));
            biases[i] = 26'sd0;
        end
        send_image(1'b0);
        checks++; if (class_idx !== 4'd0) begin errors++; $display("FAIL neg_idx got %0d exp 0", class_idx); end
`ifdef RELU_EN
        checks++; if (class_score !== 26'sd0) begin errors++; $display("FAIL neg_score got %0d exp 0", class_score); end
`else
        checks++; if (class_score !== -26'sd10) begin errors++; $display("FAIL neg_score got %0d exp -10", class_score); end
`endif
        @(negedge clk);
    endtask

    task automatic test_gaps;
        dp_valid = 1'b1;
        dp_value = 26'sd2000;
        dp_bias  = 26'sd0;
        repeat (3) @(negedge clk);
        checks++; if (dp_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_valid got ready=%0b busy=%0b exp 0 0", dp_ready, busy); end
        dp_valid = 1'b0;
        fill(26'sd5, 26'sd0);
        vals[4] = 26'sd777;
        send_image(1'b1);
        checks++; if (class_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %0b exp 1", class_valid); end
        checks++; if (class_idx !== 4'd4 || class_score !== 26'sd777) begin errors++; $display("FAIL gaps_result got idx=%0d score=%0d exp 4 777", class_idx, class_score); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        fill(26'sd1, 26'sd2);
        vals[9] = 26'sd50;
        send_image(1'b0);
        checks++; if (class_idx !== 4'd9 || class_score !== 26'sd52) begin errors++; $display("FAIL b2b_first got idx=%0d score=%0d exp 9 52", class_idx, class_score); end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done got busy=%0b exp 0", busy); end
        fill(26'sd100, 26'sd0);
        biases[6] = 26'sd1;
        send_image(1'b0);
        checks++; if (class_idx !== 4'd6 || class_score !== 26'sd101) begin errors++; $display("FAIL b2b_second got idx=%0d score=%0d exp 6 101", class_idx, class_score); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dp_valid = 1'b1;
            dp_value = (i == 2) ? 26'sd4000 : 26'sd7;
            dp_bias  = 26'sd0;
            @(negedge clk);
        end
        GlobalReset = 1'b1;
        #1;
        checks++; if (class_idx !== 4'd0 || class_score !== 26'sd0) begin errors++; $display("FAIL midreset_result got idx=%0d score=%0d exp 0 0", class_idx, class_score); end
        checks++; if (busy !== 1'b0 || dp_ready !== 1'b0 || class_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags got busy=%0b ready=%0b valid=%0b exp 0 0 0", busy, dp_ready, class_valid); end
        dp_valid = 1'b0;
        @(negedge clk) GlobalReset = 1'b0;
        fill(26'sd3, 26'sd0);
        vals[8] = 26'sd60;
        send_image(1'b0);
        checks++; if (class_valid !== 1'b1 || class_idx !== 4'd8 || class_score !== 26'sd60) begin errors++; $display("FAIL midreset_fresh got valid=%0b idx=%0d score=%0d exp 1 8 60", class_valid, class_idx, class_score); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_negative();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
